// File: rtl/avg_uart_pkg.sv
// Shared definitions for the averaged-sample UART transmitter:
// FSM state encoding, sample width and number of bytes per frame.
package avg_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int SAMPLE_W        = 10;
    localparam int BYTES_PER_FRAME = 2;

endpackage

// File: rtl/avg_sample_fifo.sv
// Small first-in first-out sample buffer. Pointers wrap modulo DEPTH
// (DEPTH is a power of two). A push while full is only taken when a
// pop happens in the same cycle; the read data is shown combinationally.
module avg_sample_fifo
    import avg_uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array: written on every accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/avg_uart_tx.sv
// Buffers 10-bit averaged samples and sends each as two 8N1 UART bytes:
// first {6'b0, sample[9:8]}, then sample[7:0], back to back.
// Optional feature: define AVG_UART_TX_PARITY_EN to insert an even parity
// bit between the data bits and the stop bit of every byte.
module avg_uart_tx
    import avg_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [9:0]                    avg_in,
    input  logic                          avg_valid,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic             LAST_BYTE = 1'(BYTES_PER_FRAME - 1);

    state_t              state;
    state_t              state_next;
    logic                pop;
    logic                push_req;
    logic                full;
    logic                empty;
    logic [SAMPLE_W-1:0] fifo_dout;
    logic [SAMPLE_W-1:0] hold;
    logic [7:0]          shift;
    logic [7:0]          byte_cur;
    logic [CNT_W-1:0]    clk_cnt;
    logic [2:0]          bit_idx;
    logic                byte_idx;
    logic                tick;

    assign push_req = avg_valid && ena;
    assign tick     = (clk_cnt == LAST_CNT);
    assign byte_cur = byte_idx ? hold[7:0] : {6'b000000, hold[9:8]};
    assign busy     = (state != IDLE) || pop;

    avg_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop),
        .din   (avg_in),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a pop is only issued from IDLE while enabled.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (ena && !empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick && (bit_idx == 3'd7)) begin
`ifdef AVG_UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = (byte_idx == LAST_BYTE) ? IDLE : START;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit timing, hold register and shifter; the shifter is loaded at the end of START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= 1'b0;
            hold     <= '0;
            shift    <= '0;
        end else if (pop) begin
            hold     <= fifo_dout;
            byte_idx <= 1'b0;
            bit_idx  <= '0;
            clk_cnt  <= '0;
        end else if (state != IDLE) begin
            clk_cnt <= tick ? '0 : clk_cnt + 1'b1;
            if (tick) begin
                case (state)
                    START: shift <= byte_cur;
                    DATA: begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                    STOP:  byte_idx <= byte_idx + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push_req && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // Line driver: idle and stop are high, start is low.
    always_comb begin
        tx = 1'b1;
        case (state)
            START:  tx = 1'b0;
            DATA:   tx = shift[0];
`ifdef AVG_UART_TX_PARITY_EN
            PARITY: tx = ^byte_cur;
`endif
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_avg_uart_tx.sv
// Self-checking bench for avg_uart_tx: a UART receiver monitor pops
// expected bytes from a scoreboard queue filled when samples are driven.
module tb_avg_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef AVG_UART_TX_PARITY_EN
    localparam int BITS_PER_BYTE = 11;
`else
    localparam int BITS_PER_BYTE = 10;
`endif
    localparam int FRAME = 2 * BITS_PER_BYTE * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [9:0] avg_in = '0;
    logic       avg_valid = 1'b0;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [$clog2(DEPTH):0] fifo_level;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         byte_phase = 0;
    int         prev_start = 0;
    logic [7:0] exp_q [$];

    avg_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .avg_in     (avg_in),
        .avg_valid  (avg_valid),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Queue both bytes of a sample on the scoreboard.
    task automatic expectSample(input logic [9:0] s);
        exp_q.push_back({6'b000000, s[9:8]});
        exp_q.push_back(s[7:0]);
    endtask

    // One-cycle strobe; returns at the negedge after the sampling posedge.
    task automatic applyStimulus(input logic [9:0] s);
        avg_in    = s;
        avg_valid = 1'b1;
        @(negedge clk);
        avg_valid = 1'b0;
    endtask

    task automatic waitTicks(input int n, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rst_n) begin
                byte_phase = 0;
                aborted    = 1'b1;
                return;
            end
        end
    endtask

    // Sample one byte at bit centres and compare against the scoreboard.
    task automatic receiveByte();
        bit         ab;
        int         t0;
        logic       st;
        logic       sp;
        logic [7:0] data;
        logic [7:0] expb;
`ifdef AVG_UART_TX_PARITY_EN
        logic       par;
`endif
        t0 = cyc;
        waitTicks(CPB / 2, ab);
        if (ab) return;
        st = tx;
        for (int b = 0; b < 8; b++) begin
            waitTicks(CPB, ab);
            if (ab) return;
            data[b] = tx;
        end
`ifdef AVG_UART_TX_PARITY_EN
        waitTicks(CPB, ab);
        if (ab) return;
        par = tx;
`endif
        waitTicks(CPB, ab);
        if (ab) return;
        sp = tx;
        checkOutput("rx_start", 32'(st), 32'd0);
        checkOutput("rx_stop", 32'(sp), 32'd1);
        if (byte_phase == 1) begin
            checkOutput("byte_gap", 32'(t0 - prev_start), 32'(BITS_PER_BYTE * CPB));
        end
        prev_start = t0;
        byte_phase = 1 - byte_phase;
        checkOutput("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            expb = exp_q.pop_front();
            checkOutput("rx_byte", 32'(data), 32'(expb));
`ifdef AVG_UART_TX_PARITY_EN
            checkOutput("rx_parity", 32'(par), 32'(^expb));
`endif
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && (tx == 1'b0)) begin
                receiveByte();
            end
        end
    end

    // Count busy cycles starting from the current (pop) cycle.
    task automatic measureBusy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (!busy) break;
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic waitDrain(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if ((exp_q.size() == 0) && !busy && (fifo_level == 0)) break;
            @(negedge clk);
        end
        if (i == bound) begin
            checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin : stimulus
        int cnt;
        int lows;

        // Reset state
        @(negedge clk);
        #1;
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (3) @(negedge clk);

        // Single sample
        $display("[TB] single sample 0x2A5");
        expectSample(10'h2A5);
        applyStimulus(10'h2A5);
        measureBusy(cnt);
        checkOutput("single_busy_len", 32'(cnt), 32'(FRAME + 1));
        checkOutput("single_sb_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("single_busy_low", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);

        // Burst of five, first one starts the frame
        $display("[TB] burst 1..5");
        for (int i = 1; i <= 5; i++) begin
            expectSample(10'(i));
            avg_in    = 10'(i);
            avg_valid = 1'b1;
            @(negedge clk);
        end
        avg_valid = 1'b0;
        checkOutput("burst_level", 32'(fifo_level), 32'd4);
        checkOutput("burst_ovf", 32'(overflow), 32'd0);
        waitDrain(6 * FRAME + 100);
        checkOutput("burst_ovf_end", 32'(overflow), 32'd0);
        repeat (5) @(negedge clk);

        // Overflow, then a push into a full FIFO on a pop cycle
        $display("[TB] overflow");
        expectSample(10'h155);
        for (int i = 1; i <= 4; i++) expectSample(10'h200 + 10'(i));
        expectSample(10'h207);
        applyStimulus(10'h155);
        repeat (20) @(negedge clk);
        for (int i = 1; i <= 6; i++) begin
            avg_in    = 10'h200 + 10'(i);
            avg_valid = 1'b1;
            @(negedge clk);
        end
        avg_valid = 1'b0;
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_level", 32'(fifo_level), 32'd4);
        repeat (FRAME + 1 - 27) @(negedge clk);
        checkOutput("ovf_busy_tail", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("ovf_full_pre", 32'(fifo_level), 32'd4);
        applyStimulus(10'h207);
        checkOutput("full_pop_level", 32'(fifo_level), 32'd4);
        waitDrain(6 * FRAME + 100);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        repeat (5) @(negedge clk);

        // Reset mid-frame
        $display("[TB] reset mid-frame");
        expectSample(10'h3C3);
        applyStimulus(10'h3C3);
        applyStimulus(10'h111);
        repeat (99) @(negedge clk);
        checkOutput("pre_rst_level", 32'(fifo_level), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_tx", 32'(tx), 32'd1);
        checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_ovf", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        byte_phase = 0;
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (!tx || busy) lows++;
        end
        checkOutput("post_rst_quiet", 32'(lows), 32'd0);

        // Enable gating
        $display("[TB] ena gating");
        ena = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(10'h0AA + 10'(i));
        @(negedge clk);
        checkOutput("ena0_level", 32'(fifo_level), 32'd0);
        checkOutput("ena0_busy", 32'(busy), 32'd0);
        ena = 1'b1;
        expectSample(10'h1E7);
        applyStimulus(10'h1E7);
        applyStimulus(10'h0F0);
        repeat (50) @(negedge clk);
        ena = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        checkOutput("ena_drop_busy", 32'(busy), 32'd0);
        checkOutput("ena_drop_level", 32'(fifo_level), 32'd1);
        checkOutput("ena_drop_sb", 32'(exp_q.size()), 32'd0);
        expectSample(10'h0F0);
        ena = 1'b1;
        waitDrain(2 * FRAME + 100);
        repeat (5) @(negedge clk);

        // All-ones sample, frame length
        $display("[TB] sample 0x3FF");
        expectSample(10'h3FF);
        applyStimulus(10'h3FF);
        measureBusy(cnt);
        checkOutput("ones_busy_len", 32'(cnt), 32'(FRAME + 1));
        waitDrain(FRAME);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
